// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus bundle between a single master and the eSRAM slave port.
// The master modport drives the address/control/write-data side; the slave modport returns ready/response/read data.
interface ahb_lite_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite master running one SINGLE byte transfer per write/read command pulse,
// with a data-phase watchdog and registered busy/valid/err/read-data reporting.
module ahb_lite_master #(
    parameter logic [3:0]  HPROT_VALUE = 4'b0011,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr,
    input  logic [7:0]          data_in,
    input  logic                write,
    input  logic                read,
    output logic                busy,
    output logic                valid,
    output logic                err,
    output logic [7:0]          data_out,
    ahb_lite_master_if.master   ahb
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [15:0] WDOG_LAST     = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] wdog_q, wdog_d;
    logic [7:0]  wbyte_q, wbyte_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [7:0]  data_out_q, data_out_d;

    logic cmd_accept;
    logic data_done;
    logic data_timeout;

    function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_rep(input logic [7:0] b);
        return {4{b}};
    endfunction

    // Transfer-ending events seen at the current edge.
    assign cmd_accept   = (state_q == S_IDLE) && (write || read);
    assign data_done    = (state_q == S_DATA) && ahb.HREADY;
    assign data_timeout = (state_q == S_DATA) && !ahb.HREADY && (wdog_q == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wdog_q     <= '0;
            wbyte_q    <= '0;
            haddr_q    <= '0;
            htrans_q   <= HTRANS_IDLE;
            hwrite_q   <= 1'b0;
            hwdata_q   <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            wbyte_q    <= wbyte_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hwdata_q   <= hwdata_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_accept)                  state_d = S_ADDR;
            S_ADDR: if (ahb.HREADY)                  state_d = S_DATA;
            S_DATA: if (data_done || data_timeout)   state_d = S_IDLE;
            default:                                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wdog_d     = wdog_q;
        wbyte_d    = wbyte_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        hwdata_d   = hwdata_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        data_out_d = data_out_q;

        case (state_q)
            S_IDLE: begin
                // A simultaneous read is dropped: write takes priority.
                if (cmd_accept) begin
                    haddr_d  = addr;
                    hwrite_d = write;
                    wbyte_d  = data_in;
                    htrans_d = HTRANS_NONSEQ;
                    busy_d   = 1'b1;
                end
            end
            S_ADDR: begin
                if (ahb.HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    wdog_d   = '0;
                    if (hwrite_q) begin
                        hwdata_d = lane_rep(wbyte_q);
                    end
                end
            end
            S_DATA: begin
                // An ERROR response with HREADY low is only the first cycle; wait for HREADY.
                if (data_done) begin
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    if (ahb.HRESP) begin
                        err_d = 1'b1;
                    end else if (!hwrite_q) begin
                        data_out_d = lane_sel(ahb.HRDATA, haddr_q[1:0]);
                    end
                end else if (data_timeout) begin
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            default: begin
                htrans_d = HTRANS_IDLE;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign busy          = busy_q;
    assign valid         = valid_q;
    assign err           = err_q;
    assign data_out      = data_out_q;

    assign ahb.HADDR     = haddr_q;
    assign ahb.HTRANS    = htrans_q;
    assign ahb.HWRITE    = hwrite_q;
    assign ahb.HWDATA    = hwdata_q;
    assign ahb.HSIZE     = 3'b000;
    assign ahb.HBURST    = 3'b000;
    assign ahb.HPROT     = HPROT_VALUE;
    assign ahb.HMASTLOCK = 1'b0;

endmodule
